fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the pipelined ARMv8-subset processor.
- Holds the PC, drives the instruction-memory address and registers the fetched instruction and its PC for the decode stage.
- Consumes the decoder's branch controls (UncondBr, BrTaken, CondAddr19, BrAddr26) to redirect the PC and flush the wrong-path instruction.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h910003FF, bubble encoding: ADDI X31, X31, #0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall; holds the PC and IF/ID.
- BrTaken  in  1  from the decoder for the instruction in ID.
- UncondBr  in  1  from the decoder; 1 selects BrAddr26, 0 selects CondAddr19.
- CondAddr19  in  19  signed word offset (B.LT, CBZ).
- BrAddr26  in  26  signed word offset (B).
- imem_rdata  in  32  instruction at imem_addr; combinational read.
- imem_addr  out  64  equals the PC register.
- ID_instr  out  32  registered instruction for decode.
- ID_pc  out  64  registered PC of ID_instr.
- ID_valid  out  1  1 when ID_instr is a real fetched instruction, 0 for a bubble.

Behaviour:
- State: PC[63:0], ID_instr, ID_pc, ID_valid. All are registers; imem_addr = PC combinationally.
- Reset values (applied on the edge where reset=1): PC=RESET_PC, ID_instr=NOP_INSTR, ID_pc=0, ID_valid=0.
- Branch target, combinational: target = ID_pc + (SignExtend(off) << 2).
  - off = BrAddr26 when UncondBr=1, else CondAddr19.
  - Sign extension is to 64 bits; the shift is by 2.
  - Addition is modulo 2^64.
- redirect = BrTaken & ID_valid & ~stall. BrTaken with ID_valid=0 is ignored.
- Edge update, priority highest first:
  1. reset: apply reset values.
  2. stall=1: PC, ID_instr, ID_pc and ID_valid all hold, regardless of BrTaken.
  3. redirect=1: PC<=target; ID_instr<=NOP_INSTR; ID_valid<=0; ID_pc<=PC. The wrong-path fetch is squashed, costing a 1-cycle bubble.
  4. Otherwise: PC<=PC+4 (mod 2^64); ID_instr<=imem_rdata; ID_pc<=PC; ID_valid<=1.
- Latency: an instruction at PC p appears on ID_instr one edge after imem_addr=p with stall=0.
- Branch resolve: a taken branch resolves in ID. The target instruction reaches ID 2 edges after the branch was in ID.
- Stall with a pending branch: the branch stays in ID. Redirect fires on the first edge with stall=0, provided the decoder still asserts BrTaken then.
- Reset mid-operation: reset overrides stall and redirect. No branch or stall state survives reset.
- Wrap-around: PC+4 from 64'hFFFF_FFFF_FFFF_FFFC gives 0. A negative offset from a low PC wraps to high addresses. No fault is raised.
- PC[1:0] stays 00 when RESET_PC is word-aligned; no alignment checking.
- No X may propagate from outputs after reset, including when the decoder drives x on unused offset fields: only the selected offset field enters the adder.

Test Plan:
- Reset and sequential fetch: reset=1 for 2 edges -> imem_addr=0, ID_valid=0, ID_instr=0x910003FF. Release with imem returning word index -> after 3 edges ID_pc=8, ID_valid=1, imem_addr=12.
- Unconditional branch: ID_pc=0x10, BrTaken=1, UncondBr=1, BrAddr26=26'h3FFFFFE (-2) -> next edge imem_addr=0x8, ID_instr=0x910003FF, ID_valid=0. Following edge: ID_pc=0x8, ID_valid=1.
- Conditional branch: ID_pc=0x20, UncondBr=0, CondAddr19=3.
  - BrTaken=1 -> imem_addr=0x2C plus a bubble.
  - BrTaken=0 -> imem_addr=0x28, no bubble.
- Stall with pending branch: stall=1 for 2 edges with BrTaken=1 -> PC, ID_instr, ID_pc, ID_valid unchanged. Drop stall -> redirect on that edge to the target.
- Reset priority: reset=1 together with redirect and stall -> PC=0, ID_valid=0 on that edge.
- Wrap: PC=64'hFFFF_FFFF_FFFF_FFFC, no branch -> imem_addr=0. Separately, ID_pc=0, CondAddr19=19'h7FFFF, BrTaken=1 -> imem_addr=64'hFFFF_FFFF_FFFF_FFFC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: branch controls from decode, instruction-memory port and IF/ID outputs.
interface fetch_stage_if;
    logic        stall;
    logic        BrTaken;
    logic        UncondBr;
    logic [18:0] CondAddr19;
    logic [25:0] BrAddr26;
    logic [31:0] imem_rdata;
    logic [63:0] imem_addr;
    logic [31:0] ID_instr;
    logic [63:0] ID_pc;
    logic        ID_valid;

    modport master (
        output stall, BrTaken, UncondBr, CondAddr19, BrAddr26, imem_rdata,
        input  imem_addr, ID_instr, ID_pc, ID_valid
    );

    modport slave (
        input  stall, BrTaken, UncondBr, CondAddr19, BrAddr26, imem_rdata,
        output imem_addr, ID_instr, ID_pc, ID_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with PC register and IF/ID pipeline register; taken branches
// resolved in ID redirect the PC and squash the wrong-path fetch.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h910003FF
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);
    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic               id_valid;

    logic [ADDR_W-1:0]  off_sext_c;
    logic [ADDR_W-1:0]  target_c;
    logic               redirect_c;

    // Only the selected offset field reaches the adder so x on the other one stays contained.
    always_comb begin
        off_sext_c = '0;
        if (bus.UncondBr) begin
            off_sext_c = {{(ADDR_W-26){bus.BrAddr26[25]}}, bus.BrAddr26};
        end else begin
            off_sext_c = {{(ADDR_W-19){bus.CondAddr19[18]}}, bus.CondAddr19};
        end
    end

    assign target_c   = id_pc + ADDR_W'(off_sext_c << 2);
    assign redirect_c = bus.BrTaken & id_valid & ~bus.stall;

    // PC and IF/ID update: reset > stall > redirect > sequential fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (bus.stall) begin
            pc       <= pc;
            id_instr <= id_instr;
            id_pc    <= id_pc;
            id_valid <= id_valid;
        end else if (redirect_c) begin
            pc       <= target_c;
            id_instr <= NOP_INSTR;
            id_pc    <= pc;
            id_valid <= 1'b0;
        end else begin
            pc       <= pc + ADDR_W'(4);
            id_instr <= bus.imem_rdata;
            id_pc    <= pc;
            id_valid <= 1'b1;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.ID_instr  = id_instr;
    assign bus.ID_pc     = id_pc;
    assign bus.ID_valid  = id_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed test-plan sequences plus random branch/stall traffic.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h910003FF;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        valid;
    } exp_t;

    logic clk;
    logic reset;
    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: each word holds its own word index.
    assign bus.imem_rdata = 32'(bus.imem_addr >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: architectural view after the next edge.
    logic [63:0] m_pc    = 64'h0;
    logic [31:0] m_instr = NOP;
    logic [63:0] m_idpc  = 64'h0;
    logic        m_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'(a / 4);
    endfunction

    task automatic model_step(input logic rst, input logic stl, input logic brt,
                              input logic unc, input logic [18:0] c19, input logic [25:0] b26);
        logic signed [63:0] off;
        logic [63:0] old_pc;
        old_pc = m_pc;
        if (rst) begin
            m_pc = 64'h0; m_instr = NOP; m_idpc = 64'h0; m_valid = 1'b0;
        end else if (stl) begin
            // everything holds
        end else if (brt && m_valid) begin
            if (unc) off = 64'($signed(b26));
            else     off = 64'($signed(c19));
            m_pc    = m_idpc + 64'(off * 64'sd4);
            m_idpc  = old_pc;
            m_instr = NOP;
            m_valid = 1'b0;
        end else begin
            m_instr = mem_word(old_pc);
            m_idpc  = old_pc;
            m_pc    = old_pc + 64'd4;
            m_valid = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, leave the unselected offset field as x, and queue the expectation.
    task automatic cycle(input logic rst, input logic stl, input logic brt,
                         input logic unc, input logic [18:0] c19, input logic [25:0] b26);
        exp_t e;
        @(negedge clk);
        reset        = rst;
        bus.stall    = stl;
        bus.BrTaken  = brt;
        bus.UncondBr = unc;
        if (unc) begin
            bus.BrAddr26 = b26; bus.CondAddr19 = 'x;
        end else begin
            bus.CondAddr19 = c19; bus.BrAddr26 = 'x;
        end
        model_step(rst, stl, brt, unc, c19, b26);
        e.addr = m_pc; e.instr = m_instr; e.pc = m_idpc; e.valid = m_valid;
        exp_q.push_back(e);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 26'd0);
    endtask

    // Monitor: after every edge compare the DUT against the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks += 4;
            if (bus.imem_addr !== e.addr) begin
                errors++;
                $display("FAIL imem_addr t=%0t got=%h exp=%h", $time, bus.imem_addr, e.addr);
            end
            if (bus.ID_instr !== e.instr) begin
                errors++;
                $display("FAIL ID_instr t=%0t got=%h exp=%h", $time, bus.ID_instr, e.instr);
            end
            if (bus.ID_pc !== e.pc) begin
                errors++;
                $display("FAIL ID_pc t=%0t got=%h exp=%h", $time, bus.ID_pc, e.pc);
            end
            if (bus.ID_valid !== e.valid) begin
                errors++;
                $display("FAIL ID_valid t=%0t got=%b exp=%b", $time, bus.ID_valid, e.valid);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0; bus.BrTaken = 1'b0; bus.UncondBr = 1'b0;
        bus.CondAddr19 = '0; bus.BrAddr26 = '0;

        // Reset then sequential fetch up to ID_pc = 0x10.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 26'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 26'd0);
        seq(5);
        // Unconditional branch by -2 words from 0x10 -> 0x8, then refetch.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 19'd0, 26'h3FFFFFE);
        seq(7);
        // ID_pc = 0x20 now: not-taken conditional, then walk back and take it.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 19'd3, 26'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 26'd0);
        seq(9);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 19'd3, 26'd0);
        seq(2);
        // Stall with a pending branch for two edges, then release with BrTaken still high.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 19'd5, 26'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 19'd5, 26'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 19'd5, 26'd0);
        seq(2);
        // Reset wins over stall and a pending redirect.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 19'd0, 26'd7);
        // BrTaken with a bubble in ID is ignored.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 19'd0, 26'd7);
        // Wrap: ID_pc = 0 with offset -1 -> PC = ...FFFC, then PC + 4 wraps to 0.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 26'd0);
        seq(1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 19'h7FFFF, 26'd0);
        seq(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic rst, stl, brt, unc;
            rst = ($urandom_range(0, 99) == 0);
            stl = ($urandom_range(0, 3) == 0);
            brt = ($urandom_range(0, 3) == 0);
            unc = $urandom_range(0, 1) == 1;
            cycle(rst, stl, brt, unc, 19'($urandom), 26'($urandom));
        end

        @(negedge clk);
        bus.stall = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
